// File: rtl/mult4u_share_ctrl.sv
// Two-requester front end for one shared combinational 4x4 unsigned multiplier.
// Define MULT4U_DMR_EN to add a swapped-operand recompute check (CHECK state).
module mult4u_share_ctrl #(
    parameter int PRIO_FIXED = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic [3:0] mult_a,
    output logic [3:0] mult_b,
    input  logic [7:0] mult_p,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_p,
    output logic       rsp_err,
    output logic [7:0] fault_cnt
);

    typedef enum logic [1:0] {IDLE, CALC, CHECK, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] a_q, b_q;
    logic       id_q;
    logic [7:0] p_q;
    logic       rr_q;
    logic       gnt_id;
    logic       hs;

    // rr_q names the requester favoured on a tie; 0 after reset.
    always_comb begin
        gnt_id = 1'b0;
        if (req0_valid && req1_valid)
            gnt_id = (PRIO_FIXED != 0) ? 1'b0 : rr_q;
        else if (req1_valid)
            gnt_id = 1'b1;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mult_a     = 4'd0;
        mult_b     = 4'd0;
        case (state)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    state_nxt  = CALC;
                end
            end
            CALC: begin
                if (rst_n) begin
                    mult_a = a_q;
                    mult_b = b_q;
                end
`ifdef MULT4U_DMR_EN
                state_nxt = CHECK;
`else
                state_nxt = RESP;
`endif
            end
            CHECK: begin
`ifdef MULT4U_DMR_EN
                if (rst_n) begin
                    mult_a = b_q;
                    mult_b = a_q;
                end
                state_nxt = RESP;
`else
                state_nxt = IDLE;
`endif
            end
            RESP: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hs = req0_ready | req1_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= 4'd0;
            b_q   <= 4'd0;
            id_q  <= 1'b0;
            p_q   <= 8'd0;
            rr_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                a_q  <= gnt_id ? req1_a : req0_a;
                b_q  <= gnt_id ? req1_b : req0_b;
                id_q <= gnt_id;
                rr_q <= ~gnt_id;
            end
            if (state == CALC)
                p_q <= mult_p;
        end
    end

`ifdef MULT4U_DMR_EN
    logic       err_q;
    logic [7:0] fcnt_q;
    logic       mism;

    assign mism = (mult_p != p_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            fcnt_q <= 8'd0;
        end else if (state == CHECK) begin
            err_q <= mism;
            if (mism && fcnt_q != 8'hFF)
                fcnt_q <= fcnt_q + 8'd1;
        end
    end

    assign rsp_err   = err_q;
    assign fault_cnt = fcnt_q;
`else
    assign rsp_err   = 1'b0;
    assign fault_cnt = 8'd0;
`endif

    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;
    assign rsp_p     = p_q;

endmodule
